// File: rtl/processor.sv
// Single-cycle processor core: 12-bit PC register plus combinational decode,
// ALU, branch resolution and register/memory control.
module processor (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] address_imem,
    input  logic [31:0] q_imem,
    output logic [16:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    input  logic [31:0] q_dmem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB
);
    typedef enum logic [4:0] {
        OP_RTYPE = 5'b00000, OP_J    = 5'b00001, OP_BNE  = 5'b00010,
        OP_JAL   = 5'b00011, OP_JR   = 5'b00100, OP_ADDI = 5'b00101,
        OP_BLT   = 5'b00110, OP_SW   = 5'b00111, OP_LW   = 5'b01000,
        OP_SETX  = 5'b10101, OP_BEX  = 5'b10110
    } opcode_e;

    logic [11:0] pc_q, pc_d, pc_plus1;
    logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
    logic [31:0] imm, tgt, alu_b, alu_y;
    logic        ovf;

    assign opcode = q_imem[31:27];
    assign rd     = q_imem[26:22];
    assign rs     = q_imem[21:17];
    assign rt     = q_imem[16:12];
    assign shamt  = q_imem[11:7];
    assign aluop  = q_imem[6:2];
    assign imm    = {{15{q_imem[16]}}, q_imem[16:0]};
    assign tgt    = {5'b0, q_imem[26:0]};

    assign pc_plus1     = pc_q + 12'd1;
    assign address_imem = pc_q;
    assign data         = data_readRegB;

    always_comb begin
        ctrl_readRegA = rs;
        ctrl_readRegB = rt;
        case (opcode)
            OP_SW:          ctrl_readRegB = rd;
            OP_JR:          ctrl_readRegA = rd;
            OP_BNE, OP_BLT: begin ctrl_readRegA = rd; ctrl_readRegB = rs; end
            OP_BEX:         ctrl_readRegA = 5'd30;
            default: ;
        endcase
    end

    // Only R-type uses the second register as the ALU operand; everything else adds imm.
    always_comb begin
        alu_b = (opcode == OP_RTYPE) ? data_readRegB : imm;
        alu_y = data_readRegA + alu_b;
        ovf   = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (aluop)
                5'b00001: alu_y = data_readRegA - alu_b;
                5'b00010: alu_y = data_readRegA & alu_b;
                5'b00011: alu_y = data_readRegA | alu_b;
                5'b00100: alu_y = data_readRegA << shamt;
                5'b00101: alu_y = $signed(data_readRegA) >>> shamt;
                default: ;
            endcase
            if (aluop == 5'b00000)
                ovf = ~(data_readRegA[31] ^ alu_b[31]) & (alu_y[31] ^ data_readRegA[31]);
            else if (aluop == 5'b00001)
                ovf = (data_readRegA[31] ^ alu_b[31]) & (alu_y[31] ^ data_readRegA[31]);
        end else if (opcode == OP_ADDI) begin
            ovf = ~(data_readRegA[31] ^ alu_b[31]) & (alu_y[31] ^ data_readRegA[31]);
        end
        address_dmem = alu_y[16:0];
    end

    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = rd;
        data_writeReg    = alu_y;
        wren             = 1'b0;
        pc_d             = pc_plus1;
        case (opcode)
            OP_RTYPE: if (aluop <= 5'b00101) begin
                ctrl_writeEnable = 1'b1;
                if (ovf) begin
                    ctrl_writeReg = 5'd30;
                    data_writeReg = (aluop == 5'b00001) ? 32'd3 : 32'd1;
                end
            end
            OP_ADDI: begin
                ctrl_writeEnable = 1'b1;
                if (ovf) begin
                    ctrl_writeReg = 5'd30;
                    data_writeReg = 32'd2;
                end
            end
            OP_LW: begin
                ctrl_writeEnable = 1'b1;
                data_writeReg    = q_dmem;
            end
            OP_SW:  wren = 1'b1;
            OP_J:   pc_d = tgt[11:0];
            OP_JAL: begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = 5'd31;
                data_writeReg    = {20'b0, pc_plus1};
                pc_d             = tgt[11:0];
            end
            OP_JR:  pc_d = data_readRegA[11:0];
            OP_BNE: if (data_readRegA != data_readRegB) pc_d = pc_plus1 + imm[11:0];
            OP_BLT: if ($signed(data_readRegA) < $signed(data_readRegB)) pc_d = pc_plus1 + imm[11:0];
            OP_SETX: begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = 5'd30;
                data_writeReg    = tgt;
            end
            OP_BEX: if (data_readRegA != 32'd0) pc_d = tgt[11:0];
            default: ;
        endcase
        // Hold off all side effects while reset is asserted.
        if (!reset) begin
            ctrl_writeEnable = 1'b0;
            wren             = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pc_q <= 12'd0;
        else        pc_q <= pc_d;
    end
endmodule

// File: tb/tb_processor.sv
// Directed-vector bench for the single-cycle processor; register file and
// memories are stood in for by directly driven read-data inputs.
module tb_processor;
    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic [16:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB;

    int checks = 0;
    int errors = 0;

    processor dut (
        .clock(clock), .reset(reset),
        .address_imem(address_imem), .q_imem(q_imem),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] im);
        return {op, rd, rs, im};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] sh,
                                          input logic [4:0] aop);
        return {5'b00000, rd, rs, rt, sh, aop, 2'b00};
    endfunction

    function automatic logic [31:0] jtype(input logic [4:0] op, input logic [26:0] t);
        return {op, t};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic goto_pc(input logic [11:0] target);
        q_imem = jtype(5'b00001, {15'b0, target});
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        q_imem = itype(5'b00111, 5'd2, 5'd0, 17'd4200);
        data_readRegA = 0; data_readRegB = 32'd260; q_dmem = 0;
        tick(); tick();
        checks++; if (address_imem !== 12'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", address_imem); end
        checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", wren); end
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", ctrl_writeEnable); end
        q_imem = 32'd0;
        data_readRegB = 0;
        reset = 1'b1;
        tick();
        checks++; if (address_imem !== 12'd1) begin errors++; $display("FAIL first_edge_pc got %0d want 1", address_imem); end
    endtask

    task automatic test_addi();
        goto_pc(12'd0);
        q_imem = itype(5'b00101, 5'd1, 5'd0, 17'd5);
        data_readRegA = 0; data_readRegB = 0;
        #1;
        checks++; if (ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL addi_we got %b want 1", ctrl_writeEnable); end
        checks++; if (ctrl_writeReg !== 5'd1) begin errors++; $display("FAIL addi_reg got %0d want 1", ctrl_writeReg); end
        checks++; if (data_writeReg !== 32'd5) begin errors++; $display("FAIL addi_data got %0d want 5", data_writeReg); end
        checks++; if (ctrl_readRegA !== 5'd0) begin errors++; $display("FAIL addi_rega got %0d want 0", ctrl_readRegA); end
        tick();
        checks++; if (address_imem !== 12'd1) begin errors++; $display("FAIL addi_nextpc got %0d want 1", address_imem); end
        // addi overflow -> r30 = 2
        q_imem = itype(5'b00101, 5'd7, 5'd8, 17'd1);
        data_readRegA = 32'h7FFF_FFFF;
        #1;
        checks++; if (ctrl_writeReg !== 5'd30 || data_writeReg !== 32'd2) begin errors++; $display("FAIL addi_ovf got r%0d=%0d want r30=2", ctrl_writeReg, data_writeReg); end
    endtask

    task automatic test_mem();
        q_imem = itype(5'b00111, 5'd2, 5'd0, 17'd4200);
        data_readRegA = 0; data_readRegB = 32'd260;
        #1;
        checks++; if (address_dmem !== 17'd4200) begin errors++; $display("FAIL sw_addr got %0d want 4200", address_dmem); end
        checks++; if (data !== 32'd260) begin errors++; $display("FAIL sw_data got %0d want 260", data); end
        checks++; if (wren !== 1'b1) begin errors++; $display("FAIL sw_wren got %b want 1", wren); end
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL sw_we got %b want 0", ctrl_writeEnable); end
        checks++; if (ctrl_readRegB !== 5'd2) begin errors++; $display("FAIL sw_regb got %0d want 2", ctrl_readRegB); end
        q_imem = itype(5'b01000, 5'd3, 5'd0, 17'd4100);
        data_readRegB = 0; q_dmem = 32'd2;
        #1;
        checks++; if (address_dmem !== 17'd4100) begin errors++; $display("FAIL lw_addr got %0d want 4100", address_dmem); end
        checks++; if (ctrl_writeReg !== 5'd3 || data_writeReg !== 32'd2) begin errors++; $display("FAIL lw_write got r%0d=%0d want r3=2", ctrl_writeReg, data_writeReg); end
        checks++; if (wren !== 1'b0 || ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL lw_ctrl got wren=%b we=%b want 0 1", wren, ctrl_writeEnable); end
        q_dmem = 0;
    endtask

    task automatic test_branch();
        goto_pc(12'd10);
        q_imem = itype(5'b00010, 5'd1, 5'd2, 17'd3);
        data_readRegA = 32'd1; data_readRegB = 32'd2;
        #1;
        checks++; if (ctrl_readRegA !== 5'd1 || ctrl_readRegB !== 5'd2) begin errors++; $display("FAIL bne_regs got %0d %0d want 1 2", ctrl_readRegA, ctrl_readRegB); end
        tick();
        checks++; if (address_imem !== 12'd14) begin errors++; $display("FAIL bne_taken got %0d want 14", address_imem); end
        goto_pc(12'd10);
        q_imem = itype(5'b00010, 5'd1, 5'd2, 17'd3);
        data_readRegA = 32'd5; data_readRegB = 32'd5;
        tick();
        checks++; if (address_imem !== 12'd11) begin errors++; $display("FAIL bne_not_taken got %0d want 11", address_imem); end
        // blt signed: -1 < 1 branches backward by 4 from PC 20 -> 17
        goto_pc(12'd20);
        q_imem = itype(5'b00110, 5'd1, 5'd2, 17'h1FFFC);
        data_readRegA = 32'hFFFF_FFFF; data_readRegB = 32'd1;
        tick();
        checks++; if (address_imem !== 12'd17) begin errors++; $display("FAIL blt_taken got %0d want 17", address_imem); end
        q_imem = itype(5'b00110, 5'd1, 5'd2, 17'd5);
        data_readRegA = 32'd1; data_readRegB = 32'hFFFF_FFFF;
        tick();
        checks++; if (address_imem !== 12'd18) begin errors++; $display("FAIL blt_not_taken got %0d want 18", address_imem); end
    endtask

    task automatic test_alu();
        q_imem = rtype(5'd4, 5'd5, 5'd6, 5'd0, 5'd0);
        data_readRegA = 32'h7FFF_FFFF; data_readRegB = 32'd1;
        #1;
        checks++; if (ctrl_writeReg !== 5'd30 || data_writeReg !== 32'd1) begin errors++; $display("FAIL add_ovf got r%0d=%0d want r30=1", ctrl_writeReg, data_writeReg); end
        q_imem = rtype(5'd4, 5'd5, 5'd6, 5'd0, 5'd1);
        data_readRegA = 32'h8000_0000; data_readRegB = 32'd1;
        #1;
        checks++; if (ctrl_writeReg !== 5'd30 || data_writeReg !== 32'd3) begin errors++; $display("FAIL sub_ovf got r%0d=%0d want r30=3", ctrl_writeReg, data_writeReg); end
        data_readRegA = 32'd10; data_readRegB = 32'd3;
        #1;
        checks++; if (ctrl_writeReg !== 5'd4 || data_writeReg !== 32'd7) begin errors++; $display("FAIL sub got r%0d=%0d want r4=7", ctrl_writeReg, data_writeReg); end
        q_imem = rtype(5'd4, 5'd5, 5'd6, 5'd0, 5'd2);
        data_readRegA = 32'hF0F0_1234; data_readRegB = 32'h0FF0_FF00;
        #1;
        checks++; if (data_writeReg !== 32'h00F0_1200) begin errors++; $display("FAIL and got %h want 00f01200", data_writeReg); end
        q_imem = rtype(5'd4, 5'd5, 5'd6, 5'd0, 5'd3);
        #1;
        checks++; if (data_writeReg !== 32'hFFF0_FF34) begin errors++; $display("FAIL or got %h want fff0ff34", data_writeReg); end
        q_imem = rtype(5'd4, 5'd5, 5'd0, 5'd4, 5'd4);
        data_readRegA = 32'h0000_00F1;
        #1;
        checks++; if (data_writeReg !== 32'h0000_0F10) begin errors++; $display("FAIL sll got %h want 00000f10", data_writeReg); end
        q_imem = rtype(5'd4, 5'd5, 5'd0, 5'd4, 5'd5);
        data_readRegA = 32'hF000_0000;
        #1;
        checks++; if (data_writeReg !== 32'hFF00_0000) begin errors++; $display("FAIL sra got %h want ff000000", data_writeReg); end
        q_imem = rtype(5'd4, 5'd5, 5'd6, 5'd0, 5'd9);
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL bad_aluop_we got %b want 0", ctrl_writeEnable); end
        q_imem = rtype(5'd0, 5'd5, 5'd6, 5'd0, 5'd0);
        data_readRegA = 32'd1; data_readRegB = 32'd1;
        #1;
        checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd0) begin errors++; $display("FAIL r0_write got we=%b r%0d want 1 r0", ctrl_writeEnable, ctrl_writeReg); end
    endtask

    task automatic test_jumps();
        goto_pc(12'd100);
        q_imem = jtype(5'b00011, 27'd300);
        #1;
        checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd31 || data_writeReg !== 32'd101) begin errors++; $display("FAIL jal_link got we=%b r%0d=%0d want 1 r31=101", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        tick();
        checks++; if (address_imem !== 12'd300) begin errors++; $display("FAIL jal_pc got %0d want 300", address_imem); end
        q_imem = itype(5'b00100, 5'd31, 5'd0, 17'd0);
        data_readRegA = 32'd101; data_readRegB = 32'd101;
        tick();
        checks++; if (address_imem !== 12'd101) begin errors++; $display("FAIL jr_pc got %0d want 101", address_imem); end
        q_imem = jtype(5'b10101, 27'h123);
        #1;
        checks++; if (ctrl_writeReg !== 5'd30 || data_writeReg !== 32'h123 || ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL setx got r%0d=%h want r30=123", ctrl_writeReg, data_writeReg); end
        tick();
        q_imem = jtype(5'b10110, 27'd500);
        data_readRegA = 32'd0;
        #1;
        checks++; if (ctrl_readRegA !== 5'd30) begin errors++; $display("FAIL bex_rega got %0d want 30", ctrl_readRegA); end
        tick();
        checks++; if (address_imem !== 12'd103) begin errors++; $display("FAIL bex_not_taken got %0d want 103", address_imem); end
        data_readRegA = 32'h123;
        tick();
        checks++; if (address_imem !== 12'd500) begin errors++; $display("FAIL bex_taken got %0d want 500", address_imem); end
    endtask

    task automatic test_nop_wrap();
        goto_pc(12'd4095);
        q_imem = jtype(5'b11111, 27'h7FF_FFFF);
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0 || wren !== 1'b0) begin errors++; $display("FAIL unknown_op got we=%b wren=%b want 0 0", ctrl_writeEnable, wren); end
        tick();
        checks++; if (address_imem !== 12'd0) begin errors++; $display("FAIL pc_wrap got %0d want 0", address_imem); end
        tick();
        checks++; if (address_imem !== 12'd1) begin errors++; $display("FAIL unknown_op_pc got %0d want 1", address_imem); end
    endtask

    task automatic test_reset_midprogram();
        goto_pc(12'd42);
        q_imem = itype(5'b00111, 5'd2, 5'd0, 17'd4200);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (address_imem !== 12'd0) begin errors++; $display("FAIL midreset_pc got %0d want 0", address_imem); end
        checks++; if (wren !== 1'b0 || ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got wren=%b we=%b want 0 0", wren, ctrl_writeEnable); end
        tick();
        checks++; if (address_imem !== 12'd0) begin errors++; $display("FAIL midreset_hold got %0d want 0", address_imem); end
        reset = 1'b1;
        tick();
        checks++; if (address_imem !== 12'd1) begin errors++; $display("FAIL midreset_release got %0d want 1", address_imem); end
    endtask

    initial begin
        reset = 1'b0;
        q_imem = 0; q_dmem = 0; data_readRegA = 0; data_readRegB = 0;
        test_reset();
        test_addi();
        test_mem();
        test_branch();
        test_alu();
        test_jumps();
        test_nop_wrap();
        test_reset_midprogram();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 SHALL: clock  input  1  master clock; PC register updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low; asserted (0) clears PC immediately.
REQ-003 SHALL: address_imem  output  12  instruction word address, equals PC[11:0].
REQ-004 SHALL: q_imem  input  32  instruction at address_imem.
REQ-005 SHALL: address_dmem  output  17  data word address (memory below 4096, memory-mapped I/O at 4096 and above).
REQ-006 SHALL: data  output  32  store data to dmem/I/O.
REQ-007 SHALL: wren  output  1  store enable.
REQ-008 SHALL: q_dmem  input  32  load data from dmem/I/O.
REQ-009 SHALL: ctrl_writeEnable  output  1  register-file write enable.
REQ-010 SHALL: ctrl_writeReg, ctrl_readRegA, ctrl_readRegB  output  5 each  register indices.
REQ-011 SHALL: data_writeReg  output  32  register write data.
REQ-012 SHALL: data_readRegA, data_readRegB  input  32 each  register read data.

Function
REQ-013 SHALL: single-cycle execution; every output other than PC is combinational from PC, q_imem, data_readRegA/B and q_dmem.
REQ-014 SHALL: decode fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], aluop [6:2], imm [16:0] sign-extended to 32 bits, T [26:0] zero-extended.
REQ-015 SHALL: R-type (opcode 00000) operations by aluop: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll by shamt, 00101 sra by shamt; rd = op(rs, rt); any other aluop writes nothing.
REQ-016 SHALL: addi (00101): rd = rs + imm.
REQ-017 SHALL: lw (01000): address_dmem = (rs + imm)[16:0]; rd = q_dmem.
REQ-018 SHALL: sw (00111): address_dmem = (rs + imm)[16:0]; data = rd value (readRegB = rd); wren = 1.
REQ-019 SHALL: j (00001): PC = T; jal (00011): r31 = PC + 1, PC = T; jr (00100): PC = rd value.
REQ-020 SHALL: bne (00010): PC = PC + 1 + imm when rd != rs; blt (00110): branch when rd < rs as signed values; compare operands are readRegA = rd, readRegB = rs.
REQ-021 SHALL: setx (10101): r30 = T; bex (10110): PC = T when r30 != 0 (readRegA = 30).
REQ-022 SHALL: signed overflow on add, addi or sub writes r30 instead of rd, with value 1, 2 or 3 respectively.
REQ-023 SHALL: on every other instruction, PC = PC + 1, wrapping modulo 2^12.
REQ-024 SHALL: ctrl_writeEnable = 1 only for R-type (valid aluop), addi, lw, jal and setx.
REQ-025 SHALL: a write whose destination is r0 keeps ctrl_writeEnable = 1; the register file discards it.
REQ-026 SHALL: wren = 0 for every opcode except sw.
REQ-027 SHALL: unknown opcodes behave as nop: no write, no store, PC + 1.
REQ-028 SHALL: when not loading or storing, address_dmem carries the ALU result; data always carries the readRegB value.

Reset
REQ-029 SHALL: reset = 0 forces PC = 0 asynchronously and holds it while low.
REQ-030 SHALL: while reset is low, wren = 0 and ctrl_writeEnable = 0.
REQ-031 SHALL: after reset releases, the first rising edge advances PC from 0.

Verification
REQ-032 SHALL: reset low mid-program -> address_imem = 0 immediately, wren = 0, ctrl_writeEnable = 0.
REQ-033 SHALL: addi r1, r0, 5 -> ctrl_writeEnable = 1, ctrl_writeReg = 1, data_writeReg = 5; next edge address_imem = 1.
REQ-034 SHALL: sw r2, 4200(r0) with r2 = 260 -> address_dmem = 4200, data = 260, wren = 1.
REQ-035 SHALL: lw r3, 4100(r0) with q_dmem = 2 -> address_dmem = 4100, ctrl_writeReg = 3, data_writeReg = 2, wren = 0.
REQ-036 SHALL: bne r1, r2, 3 at PC 10 with r1 = 1, r2 = 2 -> next PC 14; with r1 = r2 -> next PC 11.
REQ-037 SHALL: add r4, r5, r6 with r5 = 0x7FFFFFFF, r6 = 1 -> ctrl_writeReg = 30, data_writeReg = 1.
